// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, default frame marker, byte/word widths.
package loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam logic [BYTE_W-1:0] HDR_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA_HI,
      ST_DATA_LO,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } ld_state_e;

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit XOR accumulator; clear wins over enable.
module loader_csum
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [BYTE_W-1:0] data_i,
   output logic [BYTE_W-1:0] csum_o
);

   logic [BYTE_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (clr_i)
         csum_d = '0;
      else if (en_i)
         csum_d = csum_q ^ data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         csum_q <= '0;
      else
         csum_q <= csum_d;
   end

   assign csum_o = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 16-bit words into instruction memory; holds the CPU in reset until a frame is accepted.
// Optional mid-frame idle timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 8,
   parameter logic [BYTE_W-1:0] HDR_BYTE    = HDR_BYTE_DEF,
   parameter int unsigned       TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              error
);

   if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
      $error("ADDR_W must be within 1..16");
   end
   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be nonzero");
   end

   localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

   ld_state_e         state_q, state_d;
   logic [15:0]       len_q;
   logic [BYTE_W-1:0] hi_q;
   logic [16:0]       idx_q;
   logic [BYTE_W-1:0] csum;
   logic              xfer;
   logic [15:0]       len_rx;

   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   // A byte offered alongside reload is dropped, so it never counts as a transfer.
   assign xfer   = in_valid && in_ready_q && !reload;
   assign len_rx = {len_q[15:8], in_data};

`ifdef LOADER_TIMEOUT_EN
   logic        active;
   logic        tmo_hit;
   logic [31:0] tmo_q;

   assign active  = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
   assign tmo_hit = active && !xfer && (tmo_q == TIMEOUT_CYC - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_q <= '0;
      else if (!active || xfer || reload)
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + 32'd1;
   end
`endif

   loader_csum u_csum (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (xfer && state_q == ST_IDLE && in_data == HDR_BYTE),
      .en_i   (xfer && state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO}),
      .data_i (in_data),
      .csum_o (csum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (reload) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (xfer && in_data == HDR_BYTE) state_d = ST_LEN_HI;
            ST_LEN_HI:  if (xfer) state_d = ST_LEN_LO;
            ST_LEN_LO:
               if (xfer) begin
                  if ({1'b0, len_rx} > MAX_LEN) state_d = ST_ERR;
                  else if (len_rx == '0)        state_d = ST_CSUM;
                  else                          state_d = ST_DATA_HI;
               end
            ST_DATA_HI: if (xfer) state_d = ST_DATA_LO;
            ST_DATA_LO:
               if (xfer) state_d = (idx_q + 17'd1 == {1'b0, len_q}) ? ST_CSUM : ST_DATA_HI;
            ST_CSUM:    if (xfer) state_d = (in_data == csum) ? ST_DONE : ST_ERR;
            default:    state_d = state_q;
         endcase
`ifdef LOADER_TIMEOUT_EN
         if (tmo_hit) state_d = ST_ERR;
`endif
      end
   end

   always_comb begin
      in_ready_d  = !(state_d inside {ST_DONE, ST_ERR});
      mem_we_d    = xfer && state_q == ST_DATA_LO;
      mem_addr_d  = mem_we_d ? idx_q[ADDR_W-1:0] : mem_addr_q;
      mem_wdata_d = mem_we_d ? {hi_q, in_data} : mem_wdata_q;
      done_d      = state_d == ST_DONE;
      error_d     = state_d == ST_ERR;
      cpu_rst_n_d = state_d == ST_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         hi_q        <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         if (xfer) begin
            case (state_q)
               ST_IDLE:    if (in_data == HDR_BYTE) begin
                              len_q <= '0;
                              idx_q <= '0;
                           end
               ST_LEN_HI:  len_q[15:8] <= in_data;
               ST_LEN_LO:  len_q[7:0]  <= in_data;
               ST_DATA_HI: hi_q        <= in_data;
               ST_DATA_LO: idx_q       <= idx_q + 17'd1;
               default:    ;
            endcase
         end
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader (ADDR_W=8, TIMEOUT_CYC=16).
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        reload = 1'b0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        error;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [23:0] writes[$];

   always #5 clk = ~clk;

   prog_loader #(
      .ADDR_W      (8),
      .HDR_BYTE    (8'hA5),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst_n (cpu_rst_n),
      .done      (done),
      .error     (error)
   );

   always @(negedge clk)
      if (mem_we === 1'b1) writes.push_back({mem_addr, mem_wdata});

   typedef struct packed {
      logic [3:0]  nb;
      logic [63:0] bytes;
      logic [1:0]  nw;
      logic [31:0] wdata;
      logic        exp_done;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int unsigned n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_ready: in_ready stuck at %b for byte %h", in_ready, b);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      @(negedge clk);
      writes.delete();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) @(negedge clk);
   endtask

   vec_t vecs[4];

   initial begin
      logic [63:0] bv;
      logic [31:0] wd;
      logic [7:0]  cs;
      int unsigned nbad;

      // Checksum of the good frame: 00^02^12^34^AB^CD = 42
      vecs[0] = '{nb: 4'd8, bytes: 64'hA5000212_34ABCD42, nw: 2'd2, wdata: 32'h1234_ABCD, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{nb: 4'd6, bytes: 64'h00FFA500_00000000, nw: 2'd0, wdata: 32'h0,         exp_done: 1'b1, exp_err: 1'b0};
      vecs[2] = '{nb: 4'd6, bytes: 64'hA5000100_07000000, nw: 2'd1, wdata: 32'h0007_0000, exp_done: 1'b0, exp_err: 1'b1};
      vecs[3] = '{nb: 4'd3, bytes: 64'hA5010100_00000000, nw: 2'd0, wdata: 32'h0,         exp_done: 1'b0, exp_err: 1'b1};

      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      idle(3);
      rst_n = 1'b1;
      idle(2);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 4; i++) begin
         pulse_reload();
         bv = vecs[i].bytes;
         for (int j = 0; j < int'(vecs[i].nb); j++) send(bv[63-8*j -: 8]);
         idle(3);
         wd = vecs[i].wdata;
         chk($sformatf("v%0d_nwrites", i), writes.size(), {30'd0, vecs[i].nw});
         for (int w = 0; w < int'(vecs[i].nw) && w < writes.size(); w++)
            chk($sformatf("v%0d_write%0d", i, w), {8'd0, writes[w]},
                {8'd0, 8'(w), wd[31-16*w -: 16]});
         chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
         chk($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_cpu_rst_n", i), {31'd0, cpu_rst_n}, {31'd0, vecs[i].exp_done});
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      end

      // Largest legal length: 0x0100 words, last write lands at address FF
      pulse_reload();
      send(8'hA5); send(8'h01); send(8'h00);
      idle(1);
      chk("big_len_error", {31'd0, error}, 32'd0);
      chk("big_len_ready", {31'd0, in_ready}, 32'd1);
      cs = 8'h01;
      for (int k = 0; k < 256; k++) begin
         send(8'(k));
         send(8'(k) ^ 8'h5A);
         cs = cs ^ 8'(k) ^ (8'(k) ^ 8'h5A);
      end
      send(cs);
      idle(3);
      chk("big_nwrites", writes.size(), 32'd256);
      nbad = 0;
      for (int k = 0; k < writes.size(); k++)
         if (writes[k] !== {8'(k), 8'(k), 8'(k) ^ 8'h5A}) nbad++;
      chk("big_write_bad", nbad, 32'd0);
      if (writes.size() == 256) chk("big_last_write", {8'd0, writes[255]}, 32'h00FF_FFA5);
      chk("big_done", {31'd0, done}, 32'd1);

      // reload coincident with the DATA_LO byte drops that byte
      pulse_reload();
      send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
      in_valid = 1'b1;
      in_data  = 8'h34;
      reload   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b0;
      idle(2);
      chk("rl_nwrites", writes.size(), 32'd0);
      chk("rl_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
      chk("rl_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rl_done", {31'd0, done}, 32'd0);
      bv = vecs[0].bytes;
      for (int j = 0; j < 8; j++) send(bv[63-8*j -: 8]);
      idle(3);
      chk("rl_good_nwrites", writes.size(), 32'd2);
      if (writes.size() == 2) chk("rl_good_w1", {8'd0, writes[1]}, 32'h0001_ABCD);
      chk("rl_good_done", {31'd0, done}, 32'd1);
      chk("rl_good_cpu", {31'd0, cpu_rst_n}, 32'd1);

      // Stall mid-frame in LEN_LO
      pulse_reload();
      send(8'hA5); send(8'h00);
      idle(20);
`ifdef LOADER_TIMEOUT_EN
      chk("tmo_error", {31'd0, error}, 32'd1);
      chk("tmo_in_ready", {31'd0, in_ready}, 32'd0);
`else
      chk("tmo_error", {31'd0, error}, 32'd0);
      chk("tmo_in_ready", {31'd0, in_ready}, 32'd1);
`endif

      // Asynchronous reset mid-frame
      pulse_reload();
      send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("arst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("arst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      writes.delete();
      send(8'hAB); send(8'hCD); send(8'h42);
      idle(2);
      chk("arst_no_resume", writes.size(), 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
